// File: rtl/asi_rburst_if.sv
// asi_rburst_if: AXI4 read address and read data channels between interconnect and the read slave
interface asi_rburst_if #(
  parameter int AXI_DW = 64,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 4
) ();
  logic [AXI_IW-1:0] ARID;
  logic [AXI_AW-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [AXI_IW-1:0] RID;
  logic [AXI_DW-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/asi_rburst.sv
// asi_rburst: single-clock AXI4 read slave with AR queue, beat address generator, credit-guarded R FIFO; ASI_RRESP_CHK_EN enables SLVERR for illegal bursts
module asi_rburst #(
  parameter int AXI_DW = 64,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 4,
  parameter int SLV_OD = 4,
  parameter int SLV_WS = 2,
  parameter int SLV_RD = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  asi_rburst_if.slave       axi,
  output logic              m_re,
  output logic [AXI_AW-1:0] m_raddr,
  input  logic [AXI_DW-1:0] m_rdata
);
  localparam int MAXS = $clog2(AXI_DW / 8);
  localparam int QPW = SLV_OD > 1 ? $clog2(SLV_OD) : 1;
  localparam int QCW = $clog2(SLV_OD + 1);
  localparam int FPW = SLV_RD > 1 ? $clog2(SLV_RD) : 1;
  localparam int FCW = $clog2(SLV_RD + 1);
  localparam int EW = AXI_IW + AXI_AW + 13;
  localparam int SB = AXI_IW + 4;
  localparam int RW = AXI_IW + 3 + AXI_DW;
  localparam logic [1:0] M_FIX = 2'd0, M_INC = 2'd1, M_WRP = 2'd2;
  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     q_mem [SLV_OD];
  logic [QPW-1:0]    q_wr, q_rd;
  logic [QCW-1:0]    q_cnt, q_cnt_nxt;
  logic              arready, push, pop, q_ne, issue, last_beat, r_hs, h_wrap_ok, h_err, cur_err;
  logic [AXI_IW-1:0] h_id, cur_id;
  logic [AXI_AW-1:0] h_addr, cur_addr, next_addr, incr, bound;
  logic [7:0]        h_len, cur_len, beats_left;
  logic [2:0]        h_size, cur_size;
  logic [1:0]        h_burst, cur_mode;
  logic [FCW-1:0]    credit, f_cnt;
  logic [SB-1:0]     sb_in, sb_out;
  logic [RW-1:0]     f_mem [SLV_RD];
  logic [FPW-1:0]    f_wr, f_rd;

  assign push = axi.ARVALID && arready;
  assign q_ne = q_cnt != '0;
  assign q_cnt_nxt = q_cnt + QCW'(push) - QCW'(pop);
  assign {h_id, h_addr, h_len, h_size, h_burst} = q_mem[q_rd];
  assign axi.ARREADY = arready;
  assign h_wrap_ok = h_burst == 2'b10 && (h_len == 8'd1 || h_len == 8'd3 || h_len == 8'd7 || h_len == 8'd15);
`ifdef ASI_RRESP_CHK_EN
  assign h_err = h_size > 3'(MAXS) || h_burst == 2'b11 || (h_burst == 2'b10 && !h_wrap_ok);
`else
  assign h_err = 1'b0;
`endif

  // AR queue storage, pointers and registered ready (low as soon as the queue fills)
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      for (int i = 0; i < SLV_OD; i++) q_mem[i] <= '0;
      q_wr <= '0;
      q_rd <= '0;
      q_cnt <= '0;
      arready <= 1'b0;
    end else begin
      if (push) q_mem[q_wr] <= {axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST};
      if (push) q_wr <= q_wr == QPW'(SLV_OD - 1) ? '0 : q_wr + QPW'(1);
      if (pop) q_rd <= q_rd == QPW'(SLV_OD - 1) ? '0 : q_rd + QPW'(1);
      q_cnt <= q_cnt_nxt;
      arready <= q_cnt_nxt < QCW'(SLV_OD);
    end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= IDLE;
    else state <= state_nxt;

  // next state: reload from the queue when idle or on the final beat, otherwise stay
  always_comb state_nxt = (state == IDLE || (issue && last_beat)) ? (q_ne ? BURST : IDLE) : state;

  // outputs: issue a beat while credit remains, pop the head when a burst starts
  always_comb begin
    issue = state == BURST && credit < FCW'(SLV_RD);
    pop = q_ne && (state == IDLE || (issue && last_beat));
    m_re = issue && !cur_err;
  end

  assign last_beat = beats_left == '0;
  assign m_raddr = cur_addr;
  assign incr = AXI_AW'(1) << cur_size;
  assign bound = (AXI_AW'(cur_len) + AXI_AW'(1)) << cur_size;
  assign next_addr = cur_mode == M_FIX ? cur_addr :
                     cur_mode == M_WRP ? (cur_addr & ~(bound - AXI_AW'(1))) | ((cur_addr + incr) & (bound - AXI_AW'(1))) :
                     (cur_addr & ~(incr - AXI_AW'(1))) + incr;

  // burst context: load on pop, advance address and beat count on each issue
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      cur_id <= '0;
      cur_addr <= '0;
      cur_len <= '0;
      beats_left <= '0;
      cur_size <= '0;
      cur_err <= 1'b0;
      cur_mode <= M_FIX;
    end else if (pop) begin
      cur_id <= h_id;
      cur_addr <= h_addr;
      cur_len <= h_len;
      beats_left <= h_len;
      cur_size <= h_size;
      cur_err <= h_err;
      cur_mode <= h_burst == 2'b00 ? M_FIX : h_wrap_ok ? M_WRP : M_INC;
    end else if (issue) begin
      cur_addr <= next_addr;
      beats_left <= beats_left - 8'd1;
    end

  assign sb_in = {issue, cur_id, last_beat, cur_err ? 2'b10 : 2'b00};

  generate
    if (SLV_WS == 0) begin : g_ws0
      assign sb_out = sb_in;
    end else begin : g_ws
      logic [SB-1:0] sr [SLV_WS];
      // sideband delay line matching the RAM read latency
      always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
          for (int i = 0; i < SLV_WS; i++) sr[i] <= '0;
        end else begin
          sr[0] <= sb_in;
          for (int i = 1; i < SLV_WS; i++) sr[i] <= sr[i-1];
        end
      assign sb_out = sr[SLV_WS-1];
    end
  endgenerate

  assign r_hs = axi.RVALID && axi.RREADY;

  // credit: beats issued but not yet accepted on R, bounds FIFO occupancy
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) credit <= '0;
    else credit <= credit + FCW'(issue) - FCW'(r_hs);

  // R FIFO: capture RAM data with its sideband, release on R handshake
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      for (int i = 0; i < SLV_RD; i++) f_mem[i] <= '0;
      f_wr <= '0;
      f_rd <= '0;
      f_cnt <= '0;
    end else begin
      if (sb_out[SB-1]) f_mem[f_wr] <= {sb_out[SB-2:0], m_rdata};
      if (sb_out[SB-1]) f_wr <= f_wr == FPW'(SLV_RD - 1) ? '0 : f_wr + FPW'(1);
      if (r_hs) f_rd <= f_rd == FPW'(SLV_RD - 1) ? '0 : f_rd + FPW'(1);
      f_cnt <= f_cnt + FCW'(sb_out[SB-1]) - FCW'(r_hs);
    end

  assign axi.RVALID = f_cnt != '0;
  assign {axi.RID, axi.RLAST, axi.RRESP, axi.RDATA} = f_mem[f_rd];
endmodule

// File: tb/tb_asi_rburst.sv
// tb_asi_rburst: scoreboard bench for asi_rburst with a latency-2 RAM model
module tb_asi_rburst;
  typedef struct {logic [3:0] id; logic [31:0] addr; logic last; logic [1:0] resp;} rexp_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        m_re;
  logic [31:0] m_raddr;
  logic [63:0] m_rdata;
  logic [31:0] ap0, ap1, ma;
  int          total = 0, bad = 0, cyc = 0, mre_cnt = 0;
  int          mre_cyc[$];
  rexp_t       exp_r[$];
  logic [31:0] exp_a[$];
  rexp_t       re;

  asi_rburst_if #(.AXI_DW(64), .AXI_AW(32), .AXI_IW(4)) bus ();

  asi_rburst #(.AXI_DW(64), .AXI_AW(32), .AXI_IW(4), .SLV_OD(4), .SLV_WS(2), .SLV_RD(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(bus), .m_re(m_re), .m_raddr(m_raddr), .m_rdata(m_rdata)
  );

  always #5 ACLK = ~ACLK;

  // RAM model: data for an address appears two cycles after it is presented
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    ap0 <= m_raddr;
    ap1 <= ap0;
  end
  assign m_rdata = {~ap1, ap1};

  // read-strobe monitor against expected address queue
  always @(negedge ACLK) if (ARESETn && m_re) begin
    mre_cnt++;
    mre_cyc.push_back(cyc);
    total++;
    if (exp_a.size() == 0) begin
      bad++;
      $display("FAIL m_re_unexpected: got addr %h, required no read", m_raddr);
    end else begin
      ma = exp_a.pop_front();
      if (m_raddr !== ma) begin
        bad++;
        $display("FAIL m_raddr: got %h, required %h", m_raddr, ma);
      end
    end
  end

  // R channel monitor against expected beat queue
  always @(negedge ACLK) if (ARESETn && bus.RVALID && bus.RREADY) begin
    total++;
    if (exp_r.size() == 0) begin
      bad++;
      $display("FAIL r_unexpected: got id %0d, required no beat", bus.RID);
    end else begin
      re = exp_r.pop_front();
      if ({bus.RID, bus.RLAST, bus.RRESP} !== {re.id, re.last, re.resp}) begin
        bad++;
        $display("FAIL r_side: got id=%0d last=%0d resp=%0d, required id=%0d last=%0d resp=%0d",
                 bus.RID, bus.RLAST, bus.RRESP, re.id, re.last, re.resp);
      end
      if (re.resp == 2'b00) begin
        total++;
        if (bus.RDATA !== {~re.addr, re.addr}) begin
          bad++;
          $display("FAIL r_data: got %h, required %h", bus.RDATA, {~re.addr, re.addr});
        end
      end
    end
  end

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, size, burst, i);
    logic [31:0] inc, bnd, base;
    inc = 32'd1 << size;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bnd = inc * (len + 1);
      base = a - (a % bnd);
      return base + ((a - base) + inc * i) % bnd;
    end
    return i == 0 ? a : a - (a % inc) + inc * i;
  endfunction

  task automatic push_exp(input int id, input logic [31:0] a, input int len, size, burst);
    logic err;
    err = 1'b0;
`ifdef ASI_RRESP_CHK_EN
    err = size > 3 || burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
`endif
    for (int i = 0; i <= len; i++) begin
      if (!err) exp_a.push_back(beat_addr(a, len, size, burst, i));
      exp_r.push_back('{id: 4'(id), addr: beat_addr(a, len, size, burst, i), last: i == len, resp: err ? 2'b10 : 2'b00});
    end
  endtask

  task automatic ar_hs(input int id, input logic [31:0] a, input int len, size, burst, budget, input bit model, output bit ok);
    @(negedge ACLK);
    bus.ARID = 4'(id);
    bus.ARADDR = a;
    bus.ARLEN = 8'(len);
    bus.ARSIZE = 3'(size);
    bus.ARBURST = 2'(burst);
    bus.ARVALID = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (bus.ARREADY) ok = 1'b1;
      else @(negedge ACLK);
    end
    if (ok) begin
      if (model) push_exp(id, a, len, size, burst);
      @(posedge ACLK);
    end
  endtask

  task automatic ar_idle();
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
  endtask

  task automatic check_ok(input bit ok, input int id);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ar_accept: id %0d got no ARREADY, required acceptance", id);
    end
  endtask

  task automatic drain(input int budget);
    bus.RREADY = 1'b1;
    for (int k = 0; k < budget && (exp_r.size() != 0 || exp_a.size() != 0); k++) @(negedge ACLK);
    total++;
    if (exp_r.size() != 0 || exp_a.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats and %0d reads pending, required 0", exp_r.size(), exp_a.size());
      exp_r.delete();
      exp_a.delete();
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    bus.ARID = '0;
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARSIZE = '0;
    bus.ARBURST = '0;
    repeat (2) @(negedge ACLK);
    total++;
    if ({bus.ARREADY, bus.RVALID, bus.RLAST, bus.RID, bus.RRESP} !== 9'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, required 0", {bus.ARREADY, bus.RVALID, bus.RLAST, bus.RID, bus.RRESP});
    end
    total++;
    if (bus.RDATA !== 64'd0) begin
      bad++;
      $display("FAIL reset_rdata: got %h, required 0", bus.RDATA);
    end
    total++;
    if ({m_re, m_raddr} !== 33'd0) begin
      bad++;
      $display("FAIL reset_ram: got re=%b addr=%h, required 0", m_re, m_raddr);
    end
    ARESETn = 1'b1;
    #1;
    total++;
    if (bus.ARREADY !== 1'b0) begin
      bad++;
      $display("FAIL arready_hold: got %b, required 0 before first edge", bus.ARREADY);
    end
    @(negedge ACLK);
    total++;
    if (bus.ARREADY !== 1'b1) begin
      bad++;
      $display("FAIL arready_rise: got %b, required 1", bus.ARREADY);
    end
  endtask

  task automatic test_incr();
    bit ok;
    int n, n2;
    logic [31:0] adr [4] = '{32'h1003, 32'h1008, 32'h1010, 32'h1018};
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(adr[i]);
      exp_r.push_back('{id: 4'd1, addr: adr[i], last: i == 3, resp: 2'b00});
    end
    bus.RREADY = 1'b1;
    ar_hs(1, 32'h1003, 3, 3, 1, 20, 1'b0, ok);
    check_ok(ok, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      bus.ARVALID = 1'b0;
      n++;
      if (m_re) break;
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL ar_to_mre: got %0d cycles, required 2", n);
    end
    n2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      n2++;
      if (bus.RVALID) break;
    end
    total++;
    if (n2 !== 3) begin
      bad++;
      $display("FAIL mre_to_rvalid: got %0d cycles, required 3", n2);
    end
    drain(100);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] adr [4] = '{32'h38, 32'h20, 32'h28, 32'h30};
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(adr[i]);
      exp_r.push_back('{id: 4'd2, addr: adr[i], last: i == 3, resp: 2'b00});
    end
    ar_hs(2, 32'h38, 3, 3, 2, 20, 1'b0, ok);
    check_ok(ok, 2);
    ar_idle();
    drain(100);
  endtask

  task automatic test_fixed();
    bit ok;
    int m0;
    m0 = mre_cnt;
    ar_hs(3, 32'h40, 7, 2, 0, 20, 1'b1, ok);
    check_ok(ok, 3);
    ar_idle();
    drain(100);
    total++;
    if (mre_cnt - m0 !== 8) begin
      bad++;
      $display("FAIL fixed_reads: got %0d, required 8", mre_cnt - m0);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int m0;
    m0 = mre_cnt;
    bus.RREADY = 1'b0;
    ar_hs(4, 32'h200, 15, 3, 1, 20, 1'b1, ok);
    check_ok(ok, 4);
    ar_idle();
    repeat (20) @(negedge ACLK);
    total++;
    if (mre_cnt - m0 !== 8) begin
      bad++;
      $display("FAIL stall_reads: got %0d, required 8", mre_cnt - m0);
    end
    for (int r = 0; r < 2; r++) begin
      total++;
      if ({bus.RVALID, bus.RID, bus.RDATA} !== {1'b1, 4'd4, ~32'h200, 32'h200}) begin
        bad++;
        $display("FAIL stall_head: got v=%b id=%0d data=%h, required v=1 id=4 data=%h",
                 bus.RVALID, bus.RID, bus.RDATA, {~32'h200, 32'h200});
      end
      repeat (5) @(negedge ACLK);
    end
    drain(200);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.RREADY = 1'b0;
    mre_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      ar_hs(i, 32'h300 + 32'(8 * i), 0, 3, 1, 20, 1'b1, ok);
      check_ok(ok, i);
    end
    ar_idle();
    repeat (10) @(negedge ACLK);
    total++;
    if (mre_cyc.size() != 6 || mre_cyc[5] - mre_cyc[0] != 5) begin
      bad++;
      $display("FAIL b2b_gap: got %0d reads spanning %0d cycles, required 6 spanning 5",
               mre_cyc.size(), mre_cyc.size() > 0 ? mre_cyc[mre_cyc.size()-1] - mre_cyc[0] : -1);
    end
    drain(100);
  endtask

  task automatic test_ar_full();
    bit ok;
    int acc;
    bus.RREADY = 1'b0;
    ar_hs(8, 32'h400, 15, 3, 1, 20, 1'b1, ok);
    check_ok(ok, 8);
    acc = 1;
    for (int i = 1; i < 7; i++) begin
      ar_hs(8 + i, 32'h500 + 32'(16 * i), 0, 3, 1, 6, 1'b1, ok);
      if (ok) acc++;
    end
    total++;
    if (acc !== 5) begin
      bad++;
      $display("FAIL ar_full_accept: got %0d accepted, required 5", acc);
    end
    total++;
    if (bus.ARREADY !== 1'b0) begin
      bad++;
      $display("FAIL ar_full_ready: got %b, required 0", bus.ARREADY);
    end
    ar_idle();
    drain(300);
  endtask

  task automatic test_err();
    bit ok;
    int m0;
    m0 = mre_cnt;
    ar_hs(5, 32'h100, 1, 4, 1, 20, 1'b1, ok);
    check_ok(ok, 5);
    ar_idle();
    drain(100);
    total++;
`ifdef ASI_RRESP_CHK_EN
    if (mre_cnt - m0 !== 0) begin
      bad++;
      $display("FAIL err_reads: got %0d, required 0", mre_cnt - m0);
    end
`else
    if (mre_cnt - m0 !== 2) begin
      bad++;
      $display("FAIL err_reads: got %0d, required 2", mre_cnt - m0);
    end
`endif
  endtask

  task automatic test_mid_reset();
    bit ok;
    bus.RREADY = 1'b0;
    ar_hs(6, 32'h600, 7, 3, 1, 20, 1'b1, ok);
    check_ok(ok, 6);
    ar_idle();
    repeat (6) @(negedge ACLK);
    ARESETn = 1'b0;
    exp_a.delete();
    exp_r.delete();
    #1;
    total++;
    if ({bus.ARREADY, bus.RVALID, m_re} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset: got ready/valid/re %b, required 000", {bus.ARREADY, bus.RVALID, m_re});
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    total++;
    if ({bus.ARREADY, bus.RVALID} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset: got ready/valid %b, required 10", {bus.ARREADY, bus.RVALID});
    end
    ar_hs(7, 32'h700, 1, 3, 1, 20, 1'b1, ok);
    check_ok(ok, 7);
    ar_idle();
    drain(100);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_stall();
    test_back_to_back();
    test_ar_full();
    test_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
